// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative ALU divider.
// Optional b==0 fast path is selected with DIVIDER_ZERO_FAST_EN.
package alu_div_pkg;

   typedef enum logic [1:0] {
      OP_DIVU = 2'd0,
      OP_REMU = 2'd1,
      OP_DIVS = 2'd2,
      OP_REMS = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/alu_divider_if.sv
// Request/response bundle between the execute stage and the divider.
// The CPU drives the master side; the divider is the slave.
interface alu_divider_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             is_zero;
   logic             is_negative;

   modport master (
      output start, op, a, b,
      input  c, busy, done, div_by_zero, is_zero, is_negative
   );

   modport slave (
      input  start, op, a, b,
      output c, busy, done, div_by_zero, is_zero, is_negative
   );

endinterface

// File: rtl/alu_divider_step.sv
// One radix-2 restoring division step, purely combinational.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;
   logic           ge;

   assign sh   = {rem_in, q_in[WIDTH-1]};
   assign diff = sh - {1'b0, dvs};
   // rem < dvs keeps sh < 2*dvs, so the borrow bit alone decides
   assign ge   = ~diff[WIDTH];

   always_comb begin
      rem_out = sh[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
      if (ge) begin
         rem_out = diff[WIDTH-1:0];
         q_out   = {q_in[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider beside the ALU: DIVU/REMU/DIVS/REMS.
// Define DIVIDER_ZERO_FAST_EN to finish b==0 requests in one cycle.
module alu_divider
   import alu_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   alu_divider_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] c_r;
   logic             q_neg;
   logic             r_neg;
   logic             sel_rem;
   logic             dbz;
   logic             dbz_r;
   logic             busy_r;
   logic             done_r;
   logic             accept;
   logic             fast;
   logic             pend;
   logic             b_zero;

   assign b_zero = (bus.b == '0);
   assign a_abs  = (bus.op[1] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_abs  = (bus.op[1] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .q_in    (quo),
      .dvs     (dvs),
      .rem_out (rem_nx),
      .q_out   (quo_nx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      fast     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start && !pend) begin
               accept = 1'b1;
`ifdef DIVIDER_ZERO_FAST_EN
               if (b_zero) fast = 1'b1;
               else        state_nx = S_RUN;
`else
               state_nx = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
         end
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Divide-by-zero quotient is forced; the remainder path already yields a
   assign q_fin = dbz   ? DIV_ZERO_Q[WIDTH-1:0]
                : q_neg ? -quo : quo;
   assign r_fin = r_neg ? -rem : rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         sel_rem <= 1'b0;
         dbz     <= 1'b0;
         dbz_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         c_r     <= '0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            quo     <= a_abs;
            rem     <= fast ? bus.a : '0;
            dvs     <= b_abs;
            q_neg   <= bus.op[1] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg   <= bus.op[1] & bus.a[WIDTH-1];
            sel_rem <= bus.op[0];
            dbz     <= b_zero;
            cnt     <= '0;
            busy_r  <= ~fast;
         end
         if (state == S_RUN) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
         end
         if (state == S_FIX) begin
            c_r    <= sel_rem ? r_fin : q_fin;
            dbz_r  <= dbz;
            done_r <= 1'b1;
            busy_r <= 1'b0;
         end
         if (pend) begin
            c_r    <= sel_rem ? rem : DIV_ZERO_Q[WIDTH-1:0];
            dbz_r  <= 1'b1;
            done_r <= 1'b1;
         end
      end
   end

`ifdef DIVIDER_ZERO_FAST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend <= 1'b0;
      else       pend <= fast;
   end
`else
   assign pend = 1'b0;
`endif

   assign bus.c           = c_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.is_zero     = (c_r == '0);
   assign bus.is_negative = c_r[WIDTH-1];

endmodule

// File: tb/tb_alu_divider.sv
// Directed-vector bench for alu_divider.
module tb_alu_divider;
   import alu_div_pkg::*;

`ifdef DIVIDER_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   lat;
   int   bcnt;
   bit   ok;
   logic [31:0] res;

   alu_divider_if #(.WIDTH(32)) bus ();

   alu_divider #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic issue(logic [1:0] o, logic [31:0] av, logic [31:0] bv);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(output int l, output int bc, output bit k);
      l  = 0;
      bc = bus.busy ? 1 : 0;
      k  = 1'b0;
      while (l < 100) begin
         @(posedge clk);
         #1;
         l++;
         if (bus.done) begin
            k = 1'b1;
            break;
         end
         if (bus.busy) bc++;
      end
   endtask

   task automatic run(logic [1:0] o, logic [31:0] av, logic [31:0] bv,
                      output logic [31:0] r, output int l, output int bc);
      bit k;
      issue(o, av, bv);
      wait_done(l, bc, k);
      check("done_seen", 32'(k), 32'd1);
      r = bus.c;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_c", bus.c, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk) reset = 1'b0;

      run(OP_DIVU, 32'd100, 32'd7, res, lat, bcnt);
      check("divu_c", res, 32'd14);
      check("divu_lat", 32'(lat), 32'd33);
      check("divu_busy", 32'(bcnt), 32'd33);
      check("divu_busy_done", 32'(bus.busy), 32'd0);
      check("divu_dbz", 32'(bus.div_by_zero), 32'd0);
      @(posedge clk);
      #1 check("done_width", 32'(bus.done), 32'd0);
      check("c_held", bus.c, 32'd14);

      run(OP_REMS, 32'hFFFFFF9C, 32'd7, res, lat, bcnt);
      check("rems_c", res, 32'hFFFFFFFE);
      check("rems_neg", 32'(bus.is_negative), 32'd1);
      run(OP_DIVS, 32'hFFFFFF9C, 32'd7, res, lat, bcnt);
      check("divs_c", res, 32'hFFFFFFF2);
      run(OP_DIVS, 32'd100, 32'hFFFFFFF9, res, lat, bcnt);
      check("divs_nb", res, 32'hFFFFFFF2);
      run(OP_REMS, 32'd100, 32'hFFFFFFF9, res, lat, bcnt);
      check("rems_nb", res, 32'd2);

      run(OP_DIVU, 32'd5, 32'd0, res, lat, bcnt);
      check("dz_divu_c", res, 32'hFFFFFFFF);
      check("dz_divu_flag", 32'(bus.div_by_zero), 32'd1);
      check("dz_lat", 32'(lat), 32'(ZLAT));
      run(OP_REMU, 32'd5, 32'd0, res, lat, bcnt);
      check("dz_remu_c", res, 32'd5);
      check("dz_remu_lat", 32'(lat), 32'(ZLAT));
      run(OP_REMS, 32'hFFFFFF9C, 32'd0, res, lat, bcnt);
      check("dz_rems_c", res, 32'hFFFFFF9C);
      run(OP_DIVS, 32'hFFFFFF9C, 32'd0, res, lat, bcnt);
      check("dz_divs_c", res, 32'hFFFFFFFF);
      check("dz_divs_flag", 32'(bus.div_by_zero), 32'd1);

      run(OP_DIVS, 32'h80000000, 32'hFFFFFFFF, res, lat, bcnt);
      check("ovf_divs_c", res, 32'h80000000);
      check("ovf_dbz", 32'(bus.div_by_zero), 32'd0);
      run(OP_REMS, 32'h80000000, 32'hFFFFFFFF, res, lat, bcnt);
      check("ovf_rems_c", res, 32'd0);
      check("ovf_zero", 32'(bus.is_zero), 32'd1);

      issue(OP_DIVU, 32'd1000, 32'd10);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_REMU;
      bus.a     = 32'd77;
      bus.b     = 32'd1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(lat, bcnt, ok);
      check("busy_ign_seen", 32'(ok), 32'd1);
      check("busy_ign_c", bus.c, 32'd100);
      check("busy_ign_lat", 32'(lat), 32'd23);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd50;
      bus.b     = 32'd5;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(lat, bcnt, ok);
      check("b2b_seen", 32'(ok), 32'd1);
      check("b2b_c", bus.c, 32'd10);
      check("b2b_lat", 32'(lat), 32'd33);

      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (14) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_c", bus.c, 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk) reset = 1'b0;
      bcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (bus.done) bcnt++;
      end
      check("abort_no_done", 32'(bcnt), 32'd0);
      run(OP_DIVU, 32'd9, 32'd3, res, lat, bcnt);
      check("post_abort_c", res, 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
